// File: rtl/accum_sample_fifo.sv
// Captures every change of the upstream accumulator output into a small show-ahead FIFO.
// It also flags values that break the accumulator's low-bits-zero invariant and values dropped on a full FIFO.
module accum_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic             align_err
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             align_err_q, align_err_d;

    logic change_evt;
    logic full;
    logic pop;
    logic push;

    // Handshake: the head transfers on a cycle where out_valid && out_ready.
    // While out_valid=1 and out_ready=0, out_data and out_valid hold their values.
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a new value.
    assign change_evt = (din != prev_q);
    assign full       = (level_q == (AW+1)'(DEPTH));
    assign pop        = out_valid && out_ready;
    assign push       = change_evt && (!full || pop);

    always_comb begin
        prev_d      = din;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        align_err_d = align_err_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            align_err_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + (AW+1)'(1);
            end else if (pop && !push) begin
                level_d = level_q - (AW+1)'(1);
            end
            if (change_evt && !push) begin
                overflow_d = 1'b1;
            end
            if (change_evt && (din[1:0] != 2'b00)) begin
                align_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            align_err_q <= align_err_d;
        end
    end

    // Storage has no reset; entries are only read once level says they were written.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign out_data  = mem[rd_ptr_q];
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign align_err = align_err_q;

endmodule

// File: doc/accum_sample_fifo.md
Name: accum_sample_fifo

Overview:
- Downstream consumer of the 8-bit accumulator stage.
- Each clock it compares the accumulator's `dout` with its previous value. Every new value is captured into a small show-ahead FIFO and presented on a valid/ready output port.
- It checks the accumulator's invariant that the low two bits are 0, and raises sticky error and overflow flags for the system monitor.

Parameters:
- WIDTH, 8: data width; matches accumulator `dout`.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- AW, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; 0 forces reset immediately, release is synchronous to clk.
- din  input  WIDTH  accumulator output (`dout` of upstream stage).
- clear  input  1  synchronous flush of FIFO and flags.
- out_data  output  WIDTH  FIFO head value.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head this cycle.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a new value was dropped because the FIFO was full.
- align_err  output  1  sticky: a captured value had din[1:0] != 0.

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - `prev` = 0; read and write pointers = 0; level = 0.
  - out_valid = 0; overflow = 0; align_err = 0.
  - FIFO storage is not reset. out_data is don't-care while out_valid=0.
- Change detect:
  - `prev` <= din every cycle.
  - event = (din != prev), evaluated at each posedge.
  - No event in the first cycle after reset while din is 0, since upstream also resets to 0.
- Push: on event, write din to mem[wr_ptr] and advance wr_ptr modulo DEPTH, unless the push is dropped (see full/overflow below).
- Pop: on out_valid && out_ready, advance rd_ptr modulo DEPTH.
- Output port:
  - out_data = mem[rd_ptr] (show-ahead); out_valid = (level != 0).
  - Latency: a value pushed at edge N is visible on out_data/out_valid after edge N when the FIFO was empty.
- Level update per cycle:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Full (level == DEPTH):
  - Event without pop: value dropped, overflow <= 1, pointers unchanged.
  - Event with pop in the same cycle: both happen, level stays DEPTH, no overflow.
- Empty (level == 0): out_valid=0, so no pop can occur. An event pushes normally.
- Push and pop in the same cycle at level 1: both happen, level stays 1, out_data shows the new entry after the edge.
- align_err: set on any event where din[1:0] != 0, including dropped events. The value is still pushed unchanged, whatever the error state.
- Once set, overflow and align_err stay at 1 until clear or reset.
- clear=1 (synchronous, highest priority after reset):
  - Pointers and level go to 0; overflow and align_err go to 0.
  - prev <= din, so no spurious event follows the clear.
  - Any push or pop in that cycle is discarded.
- Reset asserted mid-operation: all state returns to reset values immediately, whatever clk is doing.
- Pointer wrap: pointers are AW bits and wrap naturally. Full vs empty is resolved by `level`, not by pointer equality.
- Handshake rules:
  - out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
  - Values leave the FIFO in push order.

Test Plan:
- Reset, then din stays 0 for 10 cycles -> out_valid=0, level=0, no flags.
- din steps 0 -> 4 -> 12 -> 28, out_ready=1 -> out_data sequence 4, 12, 28, each valid for one cycle, one cycle after the change; level never exceeds 1.
- out_ready=0; din takes 5 distinct multiples of 4 (4, 8, 12, 16, 20); DEPTH=4 -> level=4, overflow=1 after the 5th event. Then out_ready=1 -> 4, 8, 12, 16 drained in order; level goes to 0.
- Level=4 and an event in the same cycle as out_ready=1 -> level stays 4, overflow stays 0, the new value ends up last in order.
- din=6 injected -> align_err=1 and 6 is delivered on out_data. Then clear pulsed with din held -> level=0, both flags 0, no new event.
- Reset pulled low mid-burst with level=3 -> out_valid=0 and level=0 immediately, before the next clk edge.
